helios_host_stream_driver: RTL and testbench

- Host-side counterpart of the single-FPGA decoder's byte-stream port.
- Accepts one full syndrome block (GRID_WIDTH_U rounds of X*Z measurement bits), serialises it into the decoder's 8-bit valid/ready input stream, then collects the decoder's 8-bit response into a wide result word.
- Also measures decode latency.
- Used in benches and as the bridge from a wide syndrome source, e.g. a measurement FIFO, into the decoder.

---
 rtl/helios_host_stream_driver_if.sv | 36 +++
 rtl/helios_host_stream_driver.sv | 130 +++++++++++++
 tb/tb_helios_host_stream_driver.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/helios_host_stream_driver_if.sv
// Bundled syndrome, decoder byte-stream and result signals of the host stream driver.
// master = the driver itself, slave = the syndrome source / decoder / result sink side.
interface helios_host_stream_driver_if #(
  parameter int GRID_WIDTH_X = 4,
  parameter int GRID_WIDTH_Z = 1,
  parameter int GRID_WIDTH_U = 3,
  parameter int RESP_BYTES   = 2,
  parameter int LAT_WIDTH    = 16
);
  logic [GRID_WIDTH_X*GRID_WIDTH_Z*GRID_WIDTH_U-1:0] syndrome_in;
  logic                    syndrome_valid;
  logic                    syndrome_ready;
  logic [7:0]              tx_data;
  logic                    tx_valid;
  logic                    tx_ready;
  logic [7:0]              rx_data;
  logic                    rx_valid;
  logic                    rx_ready;
  logic [RESP_BYTES*8-1:0] result_data;
  logic                    result_valid;
  logic                    result_ready;
  logic                    header_error;
  logic [LAT_WIDTH-1:0]    latency;

  modport master (
    input  syndrome_in, syndrome_valid, tx_ready, rx_data, rx_valid, result_ready,
    output syndrome_ready, tx_data, tx_valid, rx_ready, result_data, result_valid,
           header_error, latency
  );

  modport slave (
    output syndrome_in, syndrome_valid, tx_ready, rx_data, rx_valid, result_ready,
    input  syndrome_ready, tx_data, tx_valid, rx_ready, result_data, result_valid,
           header_error, latency
  );
endinterface

// File: rtl/helios_host_stream_driver.sv
// Serialises one syndrome block into the decoder byte stream, collects the response
// into a wide result word and measures decode latency.
//
// state     | meaning
// IDLE      | waiting for a syndrome block (syndrome_ready=1)
// SEND_HDR  | offering the 8'h80 start-of-block byte
// SEND_BODY | offering body bytes, round 0 first, LSB-first
// WAIT_RESP | counting latency until the response header arrives
// RECV      | storing response payload bytes into result_data
// DONE      | holding result_valid until result_ready
module helios_host_stream_driver #(
  parameter int GRID_WIDTH_X = 4,
  parameter int GRID_WIDTH_Z = 1,
  parameter int GRID_WIDTH_U = 3,
  parameter int RESP_BYTES   = 2,
  parameter int LAT_WIDTH    = 16
) (
  input logic clk,
  input logic reset,
  helios_host_stream_driver_if.master bus
);
  localparam int XZ   = GRID_WIDTH_X * GRID_WIDTH_Z;
  localparam int BPR  = (XZ + 7) / 8;
  localparam int BODY = BPR * GRID_WIDTH_U;
  localparam int CMAX = (BODY > RESP_BYTES) ? BODY : RESP_BYTES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [7:0] TX_HDR = 8'h80;
  localparam logic [7:0] RX_HDR = 8'h40;

  typedef enum logic [2:0] {
    IDLE, SEND_HDR, SEND_BODY, WAIT_RESP, RECV, DONE
  } state_t;

  state_t                  state, state_next;
  logic [BODY*8-1:0]       padded, shift_buf;
  logic [CW-1:0]           idx;
  logic [7:0]              tx_data_q;
  logic                    tx_valid_q;
  logic [RESP_BYTES*8-1:0] result_q;
  logic                    hdr_err_q;
  logic [LAT_WIDTH-1:0]    lat_q;
  logic                    last_body, last_slot;

  // Each round is zero-padded up to a whole number of bytes.
  always_comb begin
    padded = '0;
    for (int r = 0; r < GRID_WIDTH_U; r++)
      padded[r*BPR*8 +: XZ] = bus.syndrome_in[r*XZ +: XZ];
  end

  assign last_body = (idx == CW'(BODY - 1));
  assign last_slot = (idx == CW'(RESP_BYTES - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (bus.syndrome_valid)             state_next = SEND_HDR;
      SEND_HDR:  if (bus.tx_ready)                   state_next = SEND_BODY;
      SEND_BODY: if (bus.tx_ready && last_body)      state_next = WAIT_RESP;
      WAIT_RESP: if (bus.rx_valid)                   state_next = RECV;
      RECV:      if (bus.rx_valid && last_slot)      state_next = DONE;
      DONE:      if (bus.result_ready)               state_next = IDLE;
      default:                                       state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_buf  <= '0;
      idx        <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      result_q   <= '0;
      hdr_err_q  <= 1'b0;
      lat_q      <= '0;
    end else begin
      case (state)
        IDLE: if (bus.syndrome_valid) begin
          shift_buf  <= padded;
          idx        <= '0;
          tx_valid_q <= 1'b1;
          tx_data_q  <= TX_HDR;
        end
        SEND_HDR: if (bus.tx_ready) begin
          tx_data_q <= shift_buf[7:0];
          shift_buf <= shift_buf >> 8;
        end
        SEND_BODY: if (bus.tx_ready) begin
          if (last_body) begin
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            lat_q      <= '0;
            idx        <= '0;
          end else begin
            idx       <= idx + 1'b1;
            tx_data_q <= shift_buf[7:0];
            shift_buf <= shift_buf >> 8;
          end
        end
        WAIT_RESP: begin
          if (bus.rx_valid) begin
            if (bus.rx_data != RX_HDR) hdr_err_q <= 1'b1;
          end else if (lat_q != '1) begin
            lat_q <= lat_q + 1'b1;
          end
        end
        RECV: if (bus.rx_valid) begin
          for (int k = 0; k < RESP_BYTES; k++)
            if (idx == CW'(k)) result_q[k*8 +: 8] <= bus.rx_data;
          idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.syndrome_ready = (state == IDLE);
  assign bus.tx_valid       = tx_valid_q;
  assign bus.tx_data        = tx_data_q;
  assign bus.rx_ready       = (state == WAIT_RESP) || (state == RECV);
  assign bus.result_valid   = (state == DONE);
  assign bus.result_data    = result_q;
  assign bus.header_error   = hdr_err_q;
  assign bus.latency        = lat_q;
endmodule

// File: tb/tb_helios_host_stream_driver.sv
// Bench for helios_host_stream_driver: directed and randomised frames against a
// byte-level model of the block framing, response capture and latency rules.
module tb_helios_host_stream_driver;
  localparam int GX = 4, GZ = 1, GU = 3, RB = 2, LW = 16;
  localparam int XZ = GX * GZ, BPR = (XZ + 7) / 8, BODY = BPR * GU;
  localparam int SW = XZ * GU, PW = RB * 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  helios_host_stream_driver_if #(.GRID_WIDTH_X(GX), .GRID_WIDTH_Z(GZ), .GRID_WIDTH_U(GU),
                                 .RESP_BYTES(RB), .LAT_WIDTH(LW)) bus ();

  helios_host_stream_driver #(.GRID_WIDTH_X(GX), .GRID_WIDTH_Z(GZ), .GRID_WIDTH_U(GU),
                              .RESP_BYTES(RB), .LAT_WIDTH(LW)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  int total = 0, bad = 0;

  logic [63:0]   exp_pack, obs_pack;
  int            exp_n, obs_n;
  int            stall_viol, busy_viol, rx_viol, done_viol;
  logic          frame_timeout, obs_ready_start, obs_rvalid, obs_herr;
  logic          obs_idle_ready, obs_idle_rvalid;
  logic [PW-1:0] obs_result, obs_idle_result;
  logic [LW-1:0] obs_lat;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Expected tx stream: header, then each round's bits zero-padded to BPR bytes, LSB byte first.
  function automatic void build_expected(input logic [SW-1:0] syn);
    longint unsigned s, round_val;
    s = 64'(syn);
    exp_pack = 64'h80;
    exp_n = 1;
    for (int r = 0; r < GU; r++) begin
      round_val = (s >> (r * XZ)) & ((64'd1 << XZ) - 1);
      for (int b = 0; b < BPR; b++) begin
        exp_pack = (exp_pack << 8) | ((round_val >> (8 * b)) & 64'hFF);
        exp_n++;
      end
    end
  endfunction

  task automatic do_frame(input logic [SW-1:0] syn, input int stall_mode, input int lat_d,
                          input logic [7:0] rx_hdr, input logic [PW-1:0] payload,
                          input int hold, input bit gaps);
    int guard;
    logic prev_stall;
    logic [7:0] prev_data;
    obs_pack = '0; obs_n = 0; stall_viol = 0; busy_viol = 0; rx_viol = 0; done_viol = 0;
    frame_timeout = 1'b0;
    obs_ready_start = bus.syndrome_ready;
    bus.syndrome_in = syn;
    bus.syndrome_valid = 1'b1;
    step();
    bus.syndrome_in = SW'($urandom);
    guard = 0; prev_stall = 1'b0; prev_data = '0;
    while (obs_n < 1 + BODY && guard < 500) begin
      if (prev_stall && (bus.tx_valid !== 1'b1 || bus.tx_data !== prev_data)) stall_viol++;
      if (bus.syndrome_ready !== 1'b0) busy_viol++;
      if (bus.rx_ready !== 1'b0) rx_viol++;
      bus.syndrome_valid = 1'($urandom_range(0, 1));
      bus.rx_valid = 1'($urandom_range(0, 1));
      bus.rx_data = 8'h40;
      case (stall_mode)
        0:       bus.tx_ready = 1'b1;
        1:       bus.tx_ready = (guard % 2 == 0);
        default: bus.tx_ready = 1'($urandom_range(0, 1));
      endcase
      if (bus.tx_valid && bus.tx_ready) begin
        obs_pack = (obs_pack << 8) | 64'(bus.tx_data);
        obs_n++;
      end
      prev_stall = bus.tx_valid && !bus.tx_ready;
      prev_data = bus.tx_data;
      step();
      guard++;
    end
    if (guard >= 500) frame_timeout = 1'b1;
    bus.tx_ready = 1'b0;
    bus.syndrome_valid = 1'b0;
    if (bus.tx_valid !== 1'b0) stall_viol++;
    for (int i = 0; i < lat_d; i++) begin
      bus.rx_valid = 1'b0;
      if (bus.rx_ready !== 1'b1) rx_viol++;
      step();
    end
    if (bus.rx_ready !== 1'b1) rx_viol++;
    bus.rx_valid = 1'b1;
    bus.rx_data = rx_hdr;
    step();
    for (int k = 0; k < RB; k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin bus.rx_valid = 1'b0; step(); end
      bus.rx_valid = 1'b1;
      bus.rx_data = payload[k*8 +: 8];
      step();
    end
    bus.rx_valid = 1'b0;
    obs_result = bus.result_data; obs_rvalid = bus.result_valid;
    obs_lat = bus.latency; obs_herr = bus.header_error;
    for (int i = 0; i < hold; i++) begin
      if (bus.result_valid !== 1'b1 || bus.rx_ready !== 1'b0 || bus.syndrome_ready !== 1'b0)
        done_viol++;
      bus.rx_valid = 1'($urandom_range(0, 1));
      bus.rx_data = 8'($urandom);
      step();
      if (bus.result_data !== payload) done_viol++;
    end
    bus.rx_valid = 1'b0;
    bus.result_ready = 1'b1;
    step();
    bus.result_ready = 1'b0;
    obs_idle_ready = bus.syndrome_ready;
    obs_idle_rvalid = bus.result_valid;
    obs_idle_result = bus.result_data;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.syndrome_in = '0; bus.syndrome_valid = 1'b0; bus.tx_ready = 1'b0;
    bus.rx_data = '0; bus.rx_valid = 1'b0; bus.result_ready = 1'b0;
    repeat (3) step();
    total++; if (bus.syndrome_ready !== 1'b1) begin bad++; $display("FAIL reset_sready got %b want 1", bus.syndrome_ready); end
    total++; if (bus.tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got %b want 0", bus.tx_valid); end
    total++; if (bus.tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data got %h want 00", bus.tx_data); end
    total++; if (bus.rx_ready !== 1'b0) begin bad++; $display("FAIL reset_rx_ready got %b want 0", bus.rx_ready); end
    total++; if (bus.result_valid !== 1'b0) begin bad++; $display("FAIL reset_rvalid got %b want 0", bus.result_valid); end
    total++; if (bus.result_data !== '0) begin bad++; $display("FAIL reset_result got %h want 0", bus.result_data); end
    total++; if (bus.header_error !== 1'b0) begin bad++; $display("FAIL reset_herr got %b want 0", bus.header_error); end
    total++; if (bus.latency !== '0) begin bad++; $display("FAIL reset_latency got %0d want 0", bus.latency); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic_frame();
    do_frame(12'hA5C, 0, 5, 8'h40, 16'h013C, 0, 1'b0);
    build_expected(12'hA5C);
    total++; if (frame_timeout !== 1'b0) begin bad++; $display("FAIL basic_timeout tx bytes not all seen"); end
    total++; if (obs_n != exp_n || obs_pack !== exp_pack) begin bad++; $display("FAIL basic_tx got %0d bytes %h want %0d bytes %h", obs_n, obs_pack, exp_n, exp_pack); end
    total++; if (obs_ready_start !== 1'b1) begin bad++; $display("FAIL basic_sready_idle got %b want 1", obs_ready_start); end
    total++; if (busy_viol != 0) begin bad++; $display("FAIL basic_sready_busy got %0d want 0", busy_viol); end
    total++; if (rx_viol != 0) begin bad++; $display("FAIL basic_rx_ready got %0d bad cycles want 0", rx_viol); end
    total++; if (obs_result !== 16'h013C) begin bad++; $display("FAIL basic_result got %h want 013c", obs_result); end
    total++; if (obs_rvalid !== 1'b1) begin bad++; $display("FAIL basic_rvalid got %b want 1", obs_rvalid); end
    total++; if (obs_lat !== LW'(5)) begin bad++; $display("FAIL basic_latency got %0d want 5", obs_lat); end
    total++; if (obs_herr !== 1'b0) begin bad++; $display("FAIL basic_herr got %b want 0", obs_herr); end
    total++; if (obs_idle_ready !== 1'b1) begin bad++; $display("FAIL basic_sready_after got %b want 1", obs_idle_ready); end
  endtask

  task automatic test_stall();
    logic [PW-1:0] p;
    p = PW'($urandom);
    do_frame(12'hA5C, 1, 0, 8'h40, p, 0, 1'b0);
    build_expected(12'hA5C);
    total++; if (obs_n != exp_n || obs_pack !== exp_pack) begin bad++; $display("FAIL stall_tx got %0d bytes %h want %0d bytes %h", obs_n, obs_pack, exp_n, exp_pack); end
    total++; if (stall_viol != 0) begin bad++; $display("FAIL stall_hold got %0d unstable cycles want 0", stall_viol); end
    total++; if (obs_lat !== '0) begin bad++; $display("FAIL stall_latency got %0d want 0", obs_lat); end
    total++; if (obs_result !== p) begin bad++; $display("FAIL stall_result got %h want %h", obs_result, p); end
  endtask

  task automatic test_header_error();
    logic [PW-1:0] p1, p2;
    p1 = PW'($urandom); p2 = PW'($urandom);
    do_frame(SW'($urandom), 0, 2, 8'h41, p1, 0, 1'b0);
    total++; if (obs_herr !== 1'b1) begin bad++; $display("FAIL herr_set got %b want 1", obs_herr); end
    total++; if (obs_result !== p1) begin bad++; $display("FAIL herr_payload got %h want %h", obs_result, p1); end
    do_frame(SW'($urandom), 0, 1, 8'h40, p2, 0, 1'b0);
    total++; if (obs_herr !== 1'b1) begin bad++; $display("FAIL herr_sticky got %b want 1", obs_herr); end
    total++; if (obs_result !== p2) begin bad++; $display("FAIL herr_payload2 got %h want %h", obs_result, p2); end
  endtask

  task automatic test_done_hold();
    logic [PW-1:0] p;
    p = PW'($urandom);
    do_frame(SW'($urandom), 0, 3, 8'h40, p, 10, 1'b0);
    total++; if (done_viol != 0) begin bad++; $display("FAIL done_hold got %0d bad cycles want 0", done_viol); end
    total++; if (obs_idle_rvalid !== 1'b0) begin bad++; $display("FAIL done_release got rvalid %b want 0", obs_idle_rvalid); end
    total++; if (obs_idle_result !== p) begin bad++; $display("FAIL done_result_hold got %h want %h", obs_idle_result, p); end
  endtask

  task automatic test_random_frames();
    logic [SW-1:0] syn;
    logic [PW-1:0] p;
    int d;
    for (int f = 0; f < 25; f++) begin
      syn = SW'($urandom); p = PW'($urandom); d = $urandom_range(0, 30);
      do_frame(syn, 2, d, 8'h40, p, $urandom_range(0, 3), 1'b1);
      build_expected(syn);
      total++; if (obs_n != exp_n || obs_pack !== exp_pack || frame_timeout) begin bad++; $display("FAIL rand_tx frame %0d got %0d bytes %h want %0d bytes %h", f, obs_n, obs_pack, exp_n, exp_pack); end
      total++; if (stall_viol + busy_viol + rx_viol + done_viol != 0) begin bad++; $display("FAIL rand_handshake frame %0d got %0d violations want 0", f, stall_viol + busy_viol + rx_viol + done_viol); end
      total++; if (obs_result !== p || obs_rvalid !== 1'b1) begin bad++; $display("FAIL rand_result frame %0d got %h/%b want %h/1", f, obs_result, obs_rvalid, p); end
      total++; if (obs_lat !== LW'(d)) begin bad++; $display("FAIL rand_latency frame %0d got %0d want %0d", f, obs_lat, d); end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [SW-1:0] syn;
    bus.syndrome_in = SW'($urandom);
    bus.syndrome_valid = 1'b1;
    step();
    bus.syndrome_valid = 1'b0;
    bus.tx_ready = 1'b1;
    step();
    step();
    bus.tx_ready = 1'b0;
    reset = 1'b1;
    step();
    total++; if (bus.tx_valid !== 1'b0) begin bad++; $display("FAIL midrst_tx_valid got %b want 0", bus.tx_valid); end
    total++; if (bus.syndrome_ready !== 1'b1) begin bad++; $display("FAIL midrst_sready got %b want 1", bus.syndrome_ready); end
    total++; if (bus.header_error !== 1'b0 || bus.result_data !== '0) begin bad++; $display("FAIL midrst_clear got herr %b result %h want 0 0", bus.header_error, bus.result_data); end
    reset = 1'b0;
    syn = SW'($urandom);
    do_frame(syn, 0, 4, 8'h40, 16'hBEEF, 0, 1'b0);
    build_expected(syn);
    total++; if (obs_n != exp_n || obs_pack !== exp_pack) begin bad++; $display("FAIL midrst_restart got %0d bytes %h want %0d bytes %h", obs_n, obs_pack, exp_n, exp_pack); end
    total++; if (obs_lat !== LW'(4) || obs_result !== 16'hBEEF) begin bad++; $display("FAIL midrst_resp got lat %0d result %h want 4 beef", obs_lat, obs_result); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_stall();
    test_header_error();
    test_done_hold();
    test_random_frames();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
